regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin between requesters, 0 = fixed LSU priority.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports alu_valid, alu_rd, alu_data  input  1/5/32  ALU writeback request, destination register, value.
REQ-005 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-006 SHALL have ports lsu_valid, lsu_rd, lsu_data  input  1/5/32  load-unit writeback request, destination register, value.
REQ-007 SHALL have port lsu_ready  output  1  LSU request accepted this cycle.
REQ-008 SHALL have ports issue_valid, issue_rd  input  1/5  instruction issued that will write issue_rd.
REQ-009 SHALL have ports rs1, rs2  input  5/5  source registers to check for pending writes.
REQ-010 SHALL have ports rs1_busy, rs2_busy  output  1/1  source has an outstanding write.
REQ-011 SHALL have ports wr_en, rd, result  output  1/5/32  register-file write port drive.

Function
REQ-012 SHALL transfer a request on a cycle where its valid and ready are both 1; ready SHALL be combinational from valid inputs and arbiter state.
REQ-013 SHALL assert at most one of alu_ready, lsu_ready per cycle; a lone valid requester SHALL be granted the same cycle.
REQ-014 With both valid and RR_EN=1: grant the requester not granted most recently; the pointer SHALL update only on a transfer.
REQ-015 With both valid and RR_EN=0: grant LSU; ALU SHALL wait with ready=0.
REQ-016 Requesters SHALL hold valid, rd and data stable until ready; the block need not tolerate withdrawn requests.
REQ-017 The transferred rd/data SHALL appear on rd/result with wr_en=1 exactly one cycle after transfer (registered output, latency 1); wr_en SHALL be 0 in every other cycle.
REQ-018 A transfer with rd=0 SHALL be accepted (ready=1) but SHALL produce wr_en=0 and leave the scoreboard unchanged.
REQ-019 SHALL keep a 32-bit busy mask; issue_valid with issue_rd!=0 SHALL set busy[issue_rd] at the clock edge.
REQ-020 A transfer SHALL clear busy[rd] at the clock edge of the transfer cycle.
REQ-021 Set and clear of the same register in one cycle: set SHALL win (the newer issue stays pending).
REQ-022 busy[0] SHALL always read 0.
REQ-023 rsN_busy SHALL equal busy[rsN] from the registered mask (no same-cycle bypass of clears).
REQ-024 A transfer to a register not marked busy SHALL still write; the clear SHALL be a no-op.

Reset
REQ-025 While rst_n=0: wr_en=0, rd=0, result=0, busy=0, alu_ready=lsu_ready=0, rs1_busy=rs2_busy=0.
REQ-026 Round-robin pointer SHALL reset so that ALU wins the first contended cycle.
REQ-027 Reset assertion mid-transfer SHALL discard the transfer; no write SHALL issue after deassertion.

Structure
REQ-028 Shared package regfile_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the requester-id enum (REQ_ALU, REQ_LSU).
REQ-029 Two-way arbitration SHALL be a sub-module rr_arbiter2 (valid pair in, grant pair out, RR_EN parameter, owns the pointer); scoreboard and output register stay in the top.

Verification
REQ-030 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle wr_en=1, rd=5, result=0xDEADBEEF; following cycle wr_en=0.
REQ-031 Both valid for 4 cycles, RR_EN=1 (ALU rd=1, LSU rd=2) -> grants ALU, LSU, ALU, LSU; with RR_EN=0 -> LSU every cycle.
REQ-032 issue rd=7, then rs1=7 -> rs1_busy=1 next cycle; LSU transfer rd=7 -> rs1_busy=0 the cycle after.
REQ-033 Same cycle: issue_rd=9 and transfer rd=9 (busy[9]=1) -> busy[9] stays 1, write still occurs.
REQ-034 Transfer rd=0, data=0x1 -> ready=1, wr_en stays 0; issue rd=0 -> rs1_busy for rs1=0 stays 0.
REQ-035 rst_n low during a granted cycle -> all outputs 0 immediately; after release, first contended cycle grants ALU.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and requester ids for the writeback arbiter slice.
// Imported by the arbiter and the writeback top.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way writeback arbiter: round-robin or fixed LSU priority.
// Owns the last-granted pointer; grants are gated off during reset.
module rr_arbiter2
  import regfile_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  req_id_e    r_last;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = 2'b00;
    if (rst_n) begin
      unique case (i_valid)
        2'b01: w_grant = 2'b01;
        2'b10: w_grant = 2'b10;
        2'b11: begin
          if (RR_EN != 0)
            w_grant = (r_last == REQ_ALU) ? 2'b10 : 2'b01;
          else
            w_grant = 2'b10;
        end
        default: w_grant = 2'b00;
      endcase
    end
  end

  // Starts as if LSU won last, so ALU takes the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_LSU;
    end else if (|w_grant) begin
      r_last <= w_grant[1] ? REQ_LSU : REQ_ALU;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks ALU or LSU result, drives the regfile
// write port one cycle later and tracks pending destination regs.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       result
);

  logic [1:0]            w_grant;
  logic                  w_xfer;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [XLEN-1:0]       w_data;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;

  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_result;

  rr_arbiter2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid ({lsu_valid, alu_valid}),
    .o_grant (w_grant)
  );

  assign alu_ready = w_grant[0];
  assign lsu_ready = w_grant[1];
  assign w_xfer    = |w_grant;
  assign w_rd      = w_grant[1] ? lsu_rd   : alu_rd;
  assign w_data    = w_grant[1] ? lsu_data : alu_data;

  // x0 is never tracked: no set, no clear, no write.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && issue_rd != '0)
      w_set[issue_rd] = 1'b1;
    if (w_xfer && w_rd != '0)
      w_clr[w_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en  <= 1'b0;
      r_rd     <= '0;
      r_result <= '0;
    end else begin
      r_wr_en <= w_xfer && (w_rd != '0);
      if (w_xfer) begin
        r_rd     <= w_rd;
        r_result <= w_data;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign rd       = r_rd;
  assign result   = r_result;
  assign rs1_busy = r_busy[rs1];
  assign rs2_busy = r_busy[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus
// contention, fixed-priority and reset sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data;

  logic        a_rdy0, l_rdy0, b1_0, b2_0, we0;
  logic [4:0]  rd0;
  logic [31:0] res0;
  logic        a_rdy1, l_rdy1, b1_1, b2_1, we1;
  logic [4:0]  rd1;
  logic [31:0] res1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.RR_EN(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_ready(a_rdy0),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_ready(l_rdy0),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(b1_0), .rs2_busy(b2_0),
    .wr_en(we0), .rd(rd0), .result(res0)
  );

  regfile_wb_arbiter #(.RR_EN(0)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_ready(a_rdy1),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_ready(l_rdy1),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(b1_1), .rs2_busy(b2_1),
    .wr_en(we1), .rd(rd1), .result(res1)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_ardy;
    logic        e_lrdy;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_res;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    rs1 = 0; rs2 = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] s1, input logic [4:0] s2,
    input logic ea, input logic el, input logic ew,
    input logic [4:0] erd, input logic [31:0] eres,
    input logic eb1, input logic eb2);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.s1 = s1; v.s2 = s2;
    v.e_ardy = ea; v.e_lrdy = el; v.e_we = ew;
    v.e_rd = erd; v.e_res = eres; v.e_b1 = eb1; v.e_b2 = eb2;
    return v;
  endfunction

  initial begin
    // Each row: inputs this cycle; outputs reflect earlier edges.
    tbl[0]  = mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 5,0,
                 1,0,0, 0,0, 0,0);
    tbl[1]  = mk(0,0,0, 0,0,0, 0,0, 5,0,
                 0,0,1, 5,32'hDEADBEEF, 0,0);
    tbl[2]  = mk(0,0,0, 0,0,0, 0,0, 5,0,
                 0,0,0, 0,0, 0,0);
    tbl[3]  = mk(0,0,0, 0,0,0, 1,7, 7,0,
                 0,0,0, 0,0, 0,0);
    tbl[4]  = mk(0,0,0, 0,0,0, 0,0, 7,0,
                 0,0,0, 0,0, 1,0);
    tbl[5]  = mk(0,0,0, 1,7,32'h12345678, 0,0, 7,0,
                 0,1,0, 0,0, 1,0);
    tbl[6]  = mk(0,0,0, 0,0,0, 0,0, 7,0,
                 0,0,1, 7,32'h12345678, 0,0);
    tbl[7]  = mk(0,0,0, 0,0,0, 1,9, 0,9,
                 0,0,0, 0,0, 0,0);
    tbl[8]  = mk(1,9,32'h99, 0,0,0, 1,9, 0,9,
                 1,0,0, 0,0, 0,1);
    tbl[9]  = mk(0,0,0, 0,0,0, 0,0, 0,9,
                 0,0,1, 9,32'h99, 0,1);
    tbl[10] = mk(1,0,32'h1, 0,0,0, 1,0, 0,9,
                 1,0,0, 0,0, 0,1);
    tbl[11] = mk(0,0,0, 0,0,0, 0,0, 0,9,
                 0,0,0, 0,0, 0,1);
    tbl[12] = mk(0,0,0, 1,3,32'hA5A5, 0,0, 3,9,
                 0,1,0, 0,0, 0,1);
    tbl[13] = mk(0,0,0, 0,0,0, 0,0, 3,9,
                 0,0,1, 3,32'hA5A5, 0,1);

    idle();
    rs1 = 0; rs2 = 0;
    rst_n = 0;
    @(negedge clk);
    chk("reset wr_en", {31'b0, we0}, 0);
    chk("reset rd", {27'b0, rd0}, 0);
    chk("reset result", res0, 0);
    chk("reset busy", {30'b0, b1_0, b2_0}, 0);
    chk("reset ready", {30'b0, a_rdy0, l_rdy0}, 0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
      rs1 = tbl[i].s1; rs2 = tbl[i].s2;
      @(negedge clk);
      chk($sformatf("v%0d alu_ready", i), {31'b0, a_rdy0},
          {31'b0, tbl[i].e_ardy});
      chk($sformatf("v%0d lsu_ready", i), {31'b0, l_rdy0},
          {31'b0, tbl[i].e_lrdy});
      chk($sformatf("v%0d wr_en", i), {31'b0, we0},
          {31'b0, tbl[i].e_we});
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d rd", i), {27'b0, rd0}, {27'b0, tbl[i].e_rd});
        chk($sformatf("v%0d result", i), res0, tbl[i].e_res);
      end
      chk($sformatf("v%0d rs1_busy", i), {31'b0, b1_0},
          {31'b0, tbl[i].e_b1});
      chk($sformatf("v%0d rs2_busy", i), {31'b0, b2_0},
          {31'b0, tbl[i].e_b2});
      @(posedge clk);
      #1;
    end

    // Contention: RR alternates from ALU, fixed always picks LSU.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("rr%0d alu_ready", i), {31'b0, a_rdy0},
            (i % 2 == 0) ? 1 : 0);
        chk($sformatf("rr%0d lsu_ready", i), {31'b0, l_rdy0},
            (i % 2 == 1) ? 1 : 0);
        chk($sformatf("fx%0d alu_ready", i), {31'b0, a_rdy1}, 0);
        chk($sformatf("fx%0d lsu_ready", i), {31'b0, l_rdy1}, 1);
      end
      if (i > 0) begin
        chk($sformatf("rr%0d wr_en", i), {31'b0, we0}, 1);
        chk($sformatf("rr%0d rd", i), {27'b0, rd0},
            ((i - 1) % 2 == 0) ? 1 : 2);
        chk($sformatf("fx%0d rd", i), {27'b0, rd1}, 2);
        chk($sformatf("fx%0d result", i), res1, 32'h22);
      end
      @(posedge clk);
      #1;
    end

    // Reset asserted while a contended grant is live.
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    issue_valid = 1; issue_rd = 6; rs1 = 6;
    @(posedge clk);
    #1;
    issue_valid = 0; issue_rd = 0;
    lsu_valid = 1; lsu_rd = 8; lsu_data = 32'h88;
    @(negedge clk);
    chk("pre-rst wr_en", {31'b0, we0}, 1);
    chk("pre-rst rd", {27'b0, rd0}, 4);
    chk("pre-rst rs1_busy", {31'b0, b1_0}, 1);
    chk("pre-rst lsu_ready", {31'b0, l_rdy0}, 1);
    #1;
    rst_n = 0;
    #1;
    chk("rst alu_ready", {31'b0, a_rdy0}, 0);
    chk("rst lsu_ready", {31'b0, l_rdy0}, 0);
    chk("rst wr_en", {31'b0, we0}, 0);
    chk("rst rd", {27'b0, rd0}, 0);
    chk("rst result", res0, 0);
    chk("rst rs1_busy", {31'b0, b1_0}, 0);
    idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post-rst wr_en", {31'b0, we0}, 0);
    chk("post-rst rs1_busy", {31'b0, b1_0}, 0);
    @(posedge clk);
    #1;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
    @(negedge clk);
    chk("post-rst alu_ready", {31'b0, a_rdy0}, 1);
    chk("post-rst lsu_ready", {31'b0, l_rdy0}, 0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("post-rst write rd", {27'b0, rd0}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
